// File: rtl/tc_bit_serializer.sv
// tc_bit_serializer: captures a parallel word on an accepted load and streams
// it out one bit per accepted transfer.
//
// Handshake: a bit moves from out to the consumer on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low, out and
// last are held unchanged. A load is taken on a rising edge where
// load && ready_in; ready_in also rises in the final-transfer cycle so a new
// word can follow the previous one with no idle cycle in between.
module tc_bit_serializer #(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             ready_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic             last,
  output logic             done,
  output logic             state_dbg
);

  // Enough bits to hold WIDTH itself; the count runs WIDTH..1 while a word is
  // in flight and is 0 only in IDLE.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             head_bit;

  // The bit on offer always sits at the end of the register that leaves first.
  assign head_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign out_valid = (state_q == SHIFT);
  assign out       = out_valid & head_bit;
  assign last      = out_valid && (cnt_q == CW'(1));
  assign ready_in  = (state_q == IDLE) || (last && out_ready);
  assign xfer      = out_valid && out_ready;
  assign done      = done_q;
  assign state_dbg = (state_q == SHIFT);

  // State, word and count registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state: a load wins whenever ready_in is high (IDLE or the final
  // transfer); otherwise a transfer shifts or, on the last bit, returns to IDLE.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = xfer && last;
    if (ready_in && load) begin
      state_d = SHIFT;
      shreg_d = in;
      cnt_d   = CW'(WIDTH);
    end else if (xfer) begin
      if (last) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        cnt_d   = cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tc_bit_serializer.sv
// Bench for tc_bit_serializer: three instances (8-bit LSB-first, 8-bit
// MSB-first, 1-bit), a constant vector table, hand sequences for the corner
// cases and randomized traffic against a queue-based reference model.
module tb_tc_bit_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic       a_load, a_ready_in, a_out_valid, a_out_ready, a_out, a_last, a_done, a_state;
  logic [7:0] a_in;
  logic       b_load, b_ready_in, b_out_valid, b_out_ready, b_out, b_last, b_done, b_state;
  logic [7:0] b_in;
  logic       c_load, c_ready_in, c_out_valid, c_out_ready, c_out, c_last, c_done, c_state;
  logic [0:0] c_in;

  tc_bit_serializer #(.UUID(1), .NAME("lsb8"), .WIDTH(8), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .load(a_load), .in(a_in), .ready_in(a_ready_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out), .last(a_last),
    .done(a_done), .state_dbg(a_state));

  tc_bit_serializer #(.UUID(2), .NAME("msb8"), .WIDTH(8), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .in(b_in), .ready_in(b_ready_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out), .last(b_last),
    .done(b_done), .state_dbg(b_state));

  tc_bit_serializer #(.UUID(3), .NAME("w1"), .WIDTH(1), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .load(c_load), .in(c_in), .ready_in(c_ready_in),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out(c_out), .last(c_last),
    .done(c_done), .state_dbg(c_state));

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_q[$];     // bits still to be emitted by the active instance
  logic        exp_done = 1'b0;
  logic [63:0] cap = '0;     // emitted bits, oldest in the higher positions
  int          cap_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic ld, input logic [63:0] din, input logic ordy);
    a_load = 1'b0; a_out_ready = 1'b0;
    b_load = 1'b0; b_out_ready = 1'b0;
    c_load = 1'b0; c_out_ready = 1'b0;
    case (sel)
      0: begin a_load = ld; a_in = din[7:0]; a_out_ready = ordy; end
      1: begin b_load = ld; b_in = din[7:0]; b_out_ready = ordy; end
      default: begin c_load = ld; c_in = din[0:0]; c_out_ready = ordy; end
    endcase
  endtask

  task automatic sample(input int sel, output logic v, output logic o, output logic l,
                        output logic r, output logic d);
    case (sel)
      0: begin v = a_out_valid; o = a_out; l = a_last; r = a_ready_in; d = a_done; end
      1: begin v = b_out_valid; o = b_out; l = b_last; r = b_ready_in; d = b_done; end
      default: begin v = c_out_valid; o = c_out; l = c_last; r = c_ready_in; d = c_done; end
    endcase
  endtask

  // One clock cycle on instance sel, checked against the queue model.
  task automatic cycle(input int sel, input logic ld, input logic [63:0] din, input logic ordy);
    int   w;
    bit   lsb;
    logic busy, ev, eo, el, er, ed;
    logic v, o, l, r, d;
    w   = (sel == 2) ? 1 : 8;
    lsb = (sel != 1);
    @(negedge clk);
    drive(sel, ld, din, ordy);
    #1;
    sample(sel, v, o, l, r, d);
    busy = (exp_q.size() > 0);
    ev   = busy;
    eo   = busy ? exp_q[0] : 1'b0;
    el   = busy && (exp_q.size() == 1);
    er   = !busy || (el && ordy);
    ed   = exp_done;
    check($sformatf("u%0d.out_valid", sel), 64'(v), 64'(ev));
    check($sformatf("u%0d.out", sel),       64'(o), 64'(eo));
    check($sformatf("u%0d.last", sel),      64'(l), 64'(el));
    check($sformatf("u%0d.ready_in", sel),  64'(r), 64'(er));
    check($sformatf("u%0d.done", sel),      64'(d), 64'(ed));
    if (v === 1'b1 && ordy) begin
      cap = {cap[62:0], o};
      cap_n++;
    end
    exp_done = busy && ordy && el;
    if (busy && ordy) void'(exp_q.pop_front());
    if (er && ld)
      for (int i = 0; i < w; i++) exp_q.push_back(din[lsb ? i : w - 1 - i]);
  endtask

  task automatic drain(input int sel);
    repeat (12) cycle(sel, 1'b0, 64'd0, 1'b1);
  endtask

  // ---------------- constant vector table (instance a) ----------------
  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       ordy;
    logic       ev, eo, el, er, ed;
  } vec_t;
  vec_t tbl[11];

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pat;
    logic [3:0] bp;
    int         c0;
    logic       v, o, l, r, d;

    rst = 1'b0;
    drive(0, 1'b0, 64'd0, 1'b0);
    a_in = '0; b_in = '0; c_in = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.out",       64'(a_out),       64'd0);
    check("rst.last",      64'(a_last),      64'd0);
    check("rst.done",      64'(a_done),      64'd0);
    check("rst.ready_in",  64'(a_ready_in),  64'd1);
    check("rst.state",     64'(a_state),     64'd0);
    rst = 1'b1;

    // Table: load A5, out_ready held high, LSB first.
    pat = 8'hA5;
    tbl[0] = '{ld: 1'b1, din: 8'hA5, ordy: 1'b1, ev: 1'b0, eo: 1'b0, el: 1'b0, er: 1'b1, ed: 1'b0};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{ld: 1'b0, din: 8'h00, ordy: 1'b1, ev: 1'b1, eo: pat[k-1],
                 el: (k == 8), er: (k == 8), ed: 1'b0};
    tbl[9]  = '{ld: 1'b0, din: 8'h00, ordy: 1'b1, ev: 1'b0, eo: 1'b0, el: 1'b0, er: 1'b1, ed: 1'b1};
    tbl[10] = '{ld: 1'b0, din: 8'h00, ordy: 1'b1, ev: 1'b0, eo: 1'b0, el: 1'b0, er: 1'b1, ed: 1'b0};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drive(0, tbl[k].ld, 64'(tbl[k].din), tbl[k].ordy);
      #1;
      sample(0, v, o, l, r, d);
      check($sformatf("tbl%0d.out_valid", k), 64'(v), 64'(tbl[k].ev));
      check($sformatf("tbl%0d.out", k),       64'(o), 64'(tbl[k].eo));
      check($sformatf("tbl%0d.last", k),      64'(l), 64'(tbl[k].el));
      check($sformatf("tbl%0d.ready_in", k),  64'(r), 64'(tbl[k].er));
      check($sformatf("tbl%0d.done", k),      64'(d), 64'(tbl[k].ed));
    end
    exp_q.delete();
    exp_done = 1'b0;

    // MSB first: A5 then 01.
    c0 = cap_n;
    cycle(1, 1'b1, 64'hA5, 1'b1);
    repeat (9) cycle(1, 1'b0, 64'd0, 1'b1);
    check("msb.a5.count", 64'(cap_n - c0), 64'd8);
    check("msb.a5.bits",  64'(cap[7:0]),   64'hA5);
    c0 = cap_n;
    cycle(1, 1'b1, 64'h01, 1'b1);
    repeat (9) cycle(1, 1'b0, 64'd0, 1'b1);
    check("msb.01.count", 64'(cap_n - c0), 64'd8);
    check("msb.01.bits",  64'(cap[7:0]),   64'h01);

    // Backpressure with out_ready pattern 1,0,0,1.
    bp = 4'b1001;
    c0 = cap_n;
    cycle(0, 1'b1, 64'hA5, 1'b0);
    for (int i = 0; i < 40 && (cap_n - c0) < 8; i++)
      cycle(0, 1'b0, 64'd0, bp[3 - (i % 4)]);
    check("bp.count", 64'(cap_n - c0), 64'd8);
    check("bp.bits",  64'(cap[7:0]),   64'hA5);
    drain(0);

    // Back-to-back: FF then 00 loaded in the final-transfer cycle.
    c0 = cap_n;
    cycle(0, 1'b1, 64'hFF, 1'b1);
    repeat (7) cycle(0, 1'b0, 64'd0, 1'b1);
    cycle(0, 1'b1, 64'h00, 1'b1);
    repeat (8) cycle(0, 1'b0, 64'd0, 1'b1);
    check("b2b.count", 64'(cap_n - c0), 64'd16);
    check("b2b.bits",  64'(cap[15:0]),  64'hFF00);
    drain(0);

    // Ignored load mid-word.
    c0 = cap_n;
    cycle(0, 1'b1, 64'hA5, 1'b1);
    repeat (3) cycle(0, 1'b0, 64'd0, 1'b1);
    cycle(0, 1'b1, 64'h3C, 1'b1);
    repeat (4) cycle(0, 1'b0, 64'd0, 1'b1);
    check("ign.count", 64'(cap_n - c0), 64'd8);
    check("ign.bits",  64'(cap[7:0]),   64'hA5);
    drain(0);
    check("ign.after", 64'(cap_n - c0), 64'd8);

    // WIDTH=1: a load every cycle, each bit last with its own done pulse.
    c0 = cap_n;
    for (int k = 0; k < 6; k++) cycle(2, 1'b1, 64'(k % 2), 1'b1);
    repeat (3) cycle(2, 1'b0, 64'd0, 1'b1);
    check("w1.count", 64'(cap_n - c0), 64'd6);
    check("w1.bits",  64'(cap[5:0]),   64'b010101);

    // Reset asserted mid-word.
    cycle(0, 1'b1, 64'hC3, 1'b1);
    repeat (3) cycle(0, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.out_valid", 64'(a_out_valid), 64'd0);
    check("midrst.out",       64'(a_out),       64'd0);
    check("midrst.last",      64'(a_last),      64'd0);
    check("midrst.done",      64'(a_done),      64'd0);
    check("midrst.state",     64'(a_state),     64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_done = 1'b0;
    repeat (3) cycle(0, 1'b0, 64'd0, 1'b1);

    // Randomized traffic against the queue model on each instance.
    for (int s = 0; s < 3; s++) begin
      repeat (300)
        cycle(s, ($urandom_range(0, 2) == 0), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      drain(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
